buzz_controller: RTL and testbench
==================================

// Module: buzz_controller
// PURPOSE
//   Responder for Core's buzz request: on a rising edge of en_buzz, plays
//   beep_count tone bursts on the piezo buzzer, then pulses buzz_finished.
//   Sits between Core (en_buzz / buzz_finished) and the buzzer pin. The
//   ssd_code path is untouched.
// PARAMETERS
//   TONE_HALF  125    clk cycles per buzzer half-period (2 kHz at 500 kHz clk)
//   BEEP_ON    50000  clk cycles per tone burst
//   BEEP_OFF   25000  clk cycles of silence after each burst
//   CNT_W      17     width of the burst/gap counter; must hold BEEP_ON/BEEP_OFF
// PORTS
//   clk            in   1  system clock
//   rst            in   1  reset, asynchronous, active-low
//   en_buzz        in   1  buzz request level from Core
//   beep_count     in   3  number of bursts; 0 is treated as 1
//   buzzer         out  1  square-wave drive to piezo
//   busy           out  1  high in states ON and OFF
//   buzz_finished  out  1  one-cycle done pulse to Core
// BEHAVIOUR
//   Reset (rst=0, async): state=IDLE; buzzer=0, busy=0, buzz_finished=0.
//     Edge register en_d=0, so en_buzz already high at release of rst
//     starts a sequence.
//   Start: start = en_buzz & ~en_d, sampled each posedge. In IDLE, start
//     latches n = (beep_count==0 ? 1 : beep_count) and enters ON next cycle.
//     beep_count changes after start are ignored.
//   States
//     IDLE: outputs 0; on start -> ON.
//     ON: runs BEEP_ON cycles.
//       Tone counter and phase reset on every ON entry.
//       buzzer=1 for the first TONE_HALF cycles, then toggles every
//       TONE_HALF cycles. After BEEP_ON cycles -> OFF.
//     OFF: buzzer=0; runs BEEP_OFF cycles. After BEEP_OFF cycles,
//       decrement n; if n reaches 0 -> DONE, else -> ON.
//     DONE: buzz_finished=1 for exactly one cycle; -> IDLE.
//   buzzer=0 in every state except ON.
//   Latency: start sampled at edge k -> ON spans edges k+1 .. k+BEEP_ON.
//     buzz_finished is high during the cycle after edge k+1+n*(BEEP_ON+BEEP_OFF).
//   Abort: en_buzz=0 while in ON or OFF -> IDLE on the next edge.
//     buzzer=0 immediately from that edge; no buzz_finished.
//   No retrigger while busy: a new rising edge in ON or OFF is ignored.
//     (Possible only after a 1-cycle low, which aborts first.)
//     A rising edge in DONE is ignored.
//   en_buzz held high past DONE does not restart; Core must drop and
//     re-raise it.
//   Counters saturate-free. Reload is exact, with CNT_W sized by the
//     integrator; BEEP_ON, BEEP_OFF, TONE_HALF >= 1.
//   Reset mid-sequence: immediate return to IDLE, all outputs 0.
// TESTING (override TONE_HALF=2, BEEP_ON=8, BEEP_OFF=4, CNT_W=4)
//   1. beep_count=1, en_buzz 0->1 sampled at edge 10.
//      -> buzzer pattern 1,1,0,0,1,1,0,0 on edges 11-18, then 0.
//      -> buzz_finished high one cycle after edge 23.
//   2. beep_count=3, en_buzz rise at edge 10.
//      -> three bursts starting at edges 11, 23 and 35.
//      -> buzz_finished after edge 47; busy high edges 11-46.
//   3. beep_count=0 -> identical to scenario 1 (one burst).
//   4. beep_count=2, en_buzz drops at edge 15 (mid first burst).
//      -> buzzer=0 and state IDLE from edge 15; buzz_finished never asserts.
//   5. en_buzz held high through DONE and 20 more cycles.
//      -> exactly one buzz_finished pulse.
//      -> drop for 1 cycle and raise again -> new sequence starts.
//   6. rst pulsed low during an OFF gap.
//      -> all outputs 0 asynchronously.
//      -> after release with en_buzz=1, a fresh sequence starts.

Source files
------------

// File: rtl/buzz_controller.sv
`default_nettype none
// ============================================================================
//  Module      : buzz_controller
//  Description : Piezo buzzer sequencer for Core's buzz request. A rising
//                edge on en_buzz plays beep_count tone bursts (0 counts as
//                1). Each burst is BEEP_ON cycles of a square wave with a
//                half-period of TONE_HALF cycles. Each burst is followed by
//                BEEP_OFF cycles of silence. A one-cycle buzz_finished pulse
//                follows the last gap.
//  Ports       : clk            - system clock
//                rst            - asynchronous reset, active low
//                en_buzz        - buzz request level from Core
//                beep_count     - number of bursts (0 treated as 1)
//                buzzer         - square-wave drive to the piezo
//                busy           - high while bursts or gaps are playing
//                buzz_finished  - one-cycle completion pulse to Core
//  Revision    : 1.0 - initial release
// ============================================================================
module buzz_controller #(
    parameter int TONE_HALF = 125,
    parameter int BEEP_ON   = 50000,
    parameter int BEEP_OFF  = 25000,
    parameter int CNT_W     = 17
) (
    input  logic       clk,
    input  logic       rst,
    input  logic       en_buzz,
    input  logic [2:0] beep_count,
    output logic       buzzer,
    output logic       busy,
    output logic       buzz_finished
);

    // The tone counter only has to hold TONE_HALF-1.
    localparam int TONE_W = (TONE_HALF > 1) ? $clog2(TONE_HALF) : 1;

    localparam logic [CNT_W-1:0]  C_ON_RELOAD   = CNT_W'(BEEP_ON - 1);
    localparam logic [CNT_W-1:0]  C_OFF_RELOAD  = CNT_W'(BEEP_OFF - 1);
    localparam logic [TONE_W-1:0] C_TONE_RELOAD = TONE_W'(TONE_HALF - 1);

    typedef enum logic [1:0] {
        S_IDLE = 2'd0,
        S_ON   = 2'd1,
        S_OFF  = 2'd2,
        S_DONE = 2'd3
    } state_t;

    state_t            r_state;
    logic              r_en_d;
    logic              r_go;        // start seen last cycle; enter ON now
    logic [2:0]        r_n;         // bursts still to play, including current
    logic [CNT_W-1:0]  r_cnt;       // cycles left in current burst/gap
    logic [TONE_W-1:0] r_tone;      // cycles left in current tone half-period
    logic              r_buzzer;
    logic              r_busy;
    logic              r_finished;

    logic              w_start;

    assign w_start = en_buzz & ~r_en_d;

    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            r_state    <= S_IDLE;
            r_en_d     <= 1'b0;
            r_go       <= 1'b0;
            r_n        <= 3'd0;
            r_cnt      <= '0;
            r_tone     <= '0;
            r_buzzer   <= 1'b0;
            r_busy     <= 1'b0;
            r_finished <= 1'b0;
        end else begin
            // Edge detection runs in every state. A rise that lands
            // while busy or in DONE is therefore consumed, not deferred.
            r_en_d     <= en_buzz;
            r_finished <= 1'b0;

            case (r_state)
                S_IDLE: begin
                    r_buzzer <= 1'b0;
                    r_busy   <= 1'b0;
                    if (r_go) begin
                        r_go     <= 1'b0;
                        r_state  <= S_ON;
                        r_cnt    <= C_ON_RELOAD;
                        r_tone   <= C_TONE_RELOAD;
                        r_buzzer <= 1'b1;
                        r_busy   <= 1'b1;
                    end else if (w_start) begin
                        r_go <= 1'b1;
                        r_n  <= (beep_count == 3'd0) ? 3'd1 : beep_count;
                    end
                end

                S_ON: begin
                    if (!en_buzz) begin
                        r_state  <= S_IDLE;
                        r_buzzer <= 1'b0;
                        r_busy   <= 1'b0;
                    end else if (r_cnt == '0) begin
                        r_state  <= S_OFF;
                        r_cnt    <= C_OFF_RELOAD;
                        r_buzzer <= 1'b0;
                    end else begin
                        r_cnt <= r_cnt - 1'b1;
                        if (r_tone == '0) begin
                            r_buzzer <= ~r_buzzer;
                            r_tone   <= C_TONE_RELOAD;
                        end else begin
                            r_tone <= r_tone - 1'b1;
                        end
                    end
                end

                S_OFF: begin
                    r_buzzer <= 1'b0;
                    if (!en_buzz) begin
                        r_state <= S_IDLE;
                        r_busy  <= 1'b0;
                    end else if (r_cnt == '0) begin
                        if (r_n == 3'd1) begin
                            r_n        <= 3'd0;
                            r_state    <= S_DONE;
                            r_busy     <= 1'b0;
                            r_finished <= 1'b1;
                        end else begin
                            // Next burst restarts tone phase from the top.
                            r_n      <= r_n - 3'd1;
                            r_state  <= S_ON;
                            r_cnt    <= C_ON_RELOAD;
                            r_tone   <= C_TONE_RELOAD;
                            r_buzzer <= 1'b1;
                        end
                    end else begin
                        r_cnt <= r_cnt - 1'b1;
                    end
                end

                S_DONE: begin
                    r_state  <= S_IDLE;
                    r_buzzer <= 1'b0;
                    r_busy   <= 1'b0;
                end

                default: begin
                    r_state  <= S_IDLE;
                    r_buzzer <= 1'b0;
                    r_busy   <= 1'b0;
                end
            endcase
        end
    end

    assign buzzer        = r_buzzer;
    assign busy          = r_busy;
    assign buzz_finished = r_finished;

endmodule
`default_nettype wire

// File: tb/tb_buzz_controller.sv
`default_nettype none
// ============================================================================
//  Module      : tb_buzz_controller
//  Description : Directed self-checking bench for buzz_controller. It uses
//                small timing parameters: TONE_HALF=2, BEEP_ON=8,
//                BEEP_OFF=4 and CNT_W=4. Edge k is the edge that samples
//                the en_buzz rise. Outputs are sampled 1 time unit after
//                each rising edge.
//  Revision    : 1.0 - initial release
// ============================================================================
module tb_buzz_controller;

    logic       clk = 1'b0;
    logic       rst = 1'b0;
    logic       en_buzz = 1'b0;
    logic [2:0] beep_count = 3'd0;
    logic       buzzer;
    logic       busy;
    logic       buzz_finished;

    int n_checks = 0;
    int n_fail   = 0;

    buzz_controller #(
        .TONE_HALF (2),
        .BEEP_ON   (8),
        .BEEP_OFF  (4),
        .CNT_W     (4)
    ) dut (
        .clk           (clk),
        .rst           (rst),
        .en_buzz       (en_buzz),
        .beep_count    (beep_count),
        .buzzer        (buzzer),
        .busy          (busy),
        .buzz_finished (buzz_finished)
    );

    always #5 clk = ~clk;

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    // Expected outputs i edges after the start edge, for nb bursts.
    // The burst period is 8 on + 4 off. The tone is 1,1,0,0,... from each burst start.
    function automatic logic exp_buzz(input int i, input int nb);
        int p;
        if (i < 1 || i > 12 * nb) return 1'b0;
        p = (i - 1) % 12;
        if (p >= 8) return 1'b0;
        return ((p / 2) % 2) == 0;
    endfunction

    function automatic logic exp_busy(input int i, input int nb);
        return (i >= 1) && (i <= 12 * nb);
    endfunction

    function automatic logic exp_fin(input int i, input int nb);
        return i == 12 * nb + 1;
    endfunction

    // Return to a clean IDLE with the edge register cleared.
    task automatic go_idle();
        en_buzz = 1'b0;
        tick();
        tick();
        tick();
    endtask

    // Caller has already raised en_buzz. The first tick is edge k.
    task automatic run_sequence(input int nb, input bit scramble, input string name);
        logic eb, ey, ef;
        tick();
        for (int i = 1; i <= 12 * nb + 3; i++) begin
            tick();
            if (scramble && i == 2) beep_count = 3'd6;
            eb = exp_buzz(i, nb);
            ey = exp_busy(i, nb);
            ef = exp_fin(i, nb);
            n_checks++;
            if (buzzer !== eb) begin
                n_fail++;
                $display("FAIL %s buzzer @k+%0d: got %b expected %b", name, i, buzzer, eb);
            end
            n_checks++;
            if (busy !== ey) begin
                n_fail++;
                $display("FAIL %s busy @k+%0d: got %b expected %b", name, i, busy, ey);
            end
            n_checks++;
            if (buzz_finished !== ef) begin
                n_fail++;
                $display("FAIL %s buzz_finished @k+%0d: got %b expected %b", name, i, buzz_finished, ef);
            end
        end
    endtask

    task automatic test_reset();
        tick();
        tick();
        n_checks++;
        if ({buzzer, busy, buzz_finished} !== 3'b000) begin
            n_fail++;
            $display("FAIL reset outputs: got %b expected 000", {buzzer, busy, buzz_finished});
        end
        rst = 1'b1;
        tick();
        tick();
        n_checks++;
        if ({buzzer, busy, buzz_finished} !== 3'b000) begin
            n_fail++;
            $display("FAIL idle after reset: got %b expected 000", {buzzer, busy, buzz_finished});
        end
    endtask

    task automatic test_single();
        go_idle();
        beep_count = 3'd1;
        en_buzz    = 1'b1;
        run_sequence(1, 1'b0, "single");
    endtask

    task automatic test_three();
        go_idle();
        beep_count = 3'd3;
        en_buzz    = 1'b1;
        run_sequence(3, 1'b1, "three");
    endtask

    task automatic test_zero_count();
        go_idle();
        beep_count = 3'd0;
        en_buzz    = 1'b1;
        run_sequence(1, 1'b0, "zero_count");
    endtask

    task automatic test_abort();
        int pulses;
        int busy_seen;
        logic [3:0] pat;
        pat = 4'b0011;                  // pat[i-1]: buzzer after edge k+i
        go_idle();
        beep_count = 3'd2;
        en_buzz    = 1'b1;
        tick();                         // edge k
        for (int i = 1; i <= 4; i++) begin
            tick();
            n_checks++;
            if (buzzer !== pat[i-1] || busy !== 1'b1) begin
                n_fail++;
                $display("FAIL abort pre-drop @k+%0d: buzzer/busy got %b%b expected %b1", i, buzzer, busy, pat[i-1]);
            end
        end
        en_buzz = 1'b0;
        tick();                         // edge k+5 samples the drop
        n_checks++;
        if ({buzzer, busy, buzz_finished} !== 3'b000) begin
            n_fail++;
            $display("FAIL abort at drop: got %b expected 000", {buzzer, busy, buzz_finished});
        end
        pulses    = 0;
        busy_seen = 0;
        for (int i = 0; i < 30; i++) begin
            tick();
            if (buzz_finished === 1'b1) pulses++;
            if (busy !== 1'b0 || buzzer !== 1'b0) busy_seen++;
        end
        n_checks++;
        if (pulses !== 0) begin
            n_fail++;
            $display("FAIL abort finished pulses: got %0d expected 0", pulses);
        end
        n_checks++;
        if (busy_seen !== 0) begin
            n_fail++;
            $display("FAIL abort stays idle: active cycles got %0d expected 0", busy_seen);
        end
    endtask

    task automatic test_hold_high();
        int pulses;
        go_idle();
        beep_count = 3'd1;
        en_buzz    = 1'b1;
        tick();                         // edge k
        pulses = 0;
        for (int i = 1; i <= 33; i++) begin
            tick();
            if (buzz_finished === 1'b1) pulses++;
        end
        n_checks++;
        if (pulses !== 1) begin
            n_fail++;
            $display("FAIL hold_high finished pulses: got %0d expected 1", pulses);
        end
        n_checks++;
        if (busy !== 1'b0) begin
            n_fail++;
            $display("FAIL hold_high no restart: busy got %b expected 0", busy);
        end
        en_buzz = 1'b0;
        tick();
        en_buzz = 1'b1;
        tick();                         // new edge k
        tick();
        n_checks++;
        if (busy !== 1'b1 || buzzer !== 1'b1) begin
            n_fail++;
            $display("FAIL hold_high re-raise: busy/buzzer got %b%b expected 11", busy, buzzer);
        end
    endtask

    task automatic test_reset_mid();
        go_idle();
        beep_count = 3'd1;
        en_buzz    = 1'b1;
        tick();                         // edge k
        for (int i = 1; i <= 10; i++) tick();
        n_checks++;
        if (busy !== 1'b1 || buzzer !== 1'b0) begin
            n_fail++;
            $display("FAIL reset_mid in gap: busy/buzzer got %b%b expected 10", busy, buzzer);
        end
        #3;
        rst = 1'b0;
        #1;
        n_checks++;
        if ({buzzer, busy, buzz_finished} !== 3'b000) begin
            n_fail++;
            $display("FAIL reset_mid async clear: got %b expected 000", {buzzer, busy, buzz_finished});
        end
        tick();
        tick();
        n_checks++;
        if ({buzzer, busy, buzz_finished} !== 3'b000) begin
            n_fail++;
            $display("FAIL reset_mid held: got %b expected 000", {buzzer, busy, buzz_finished});
        end
        #2;
        rst = 1'b1;                     // en_buzz still high: next edge starts
        run_sequence(1, 1'b0, "after_reset");
    endtask

    initial begin
        #200000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1, "watchdog");
    end

    initial begin
        test_reset();
        test_single();
        test_three();
        test_zero_count();
        test_abort();
        test_hold_high();
        test_reset_mid();
        $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
        $finish;
    end

endmodule
`default_nettype wire
